// File: rtl/alu_control_mc.sv
// Registered ALU control decoder with MULT/DIV iteration counter and stall generation.
// Optional macro ALU_CTRL_SHIFT_EN enables SLL/SRL decode (otherwise those functs are illegal).
module alu_control_mc #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [5:0] funct_i,
    input  logic [1:0] ALUOp_i,
    input  logic       flush_i,
    output logic [3:0] ALUCtrl_o,
    output logic       ctrl_valid_o,
    output logic       stall_o,
    output logic       done_o,
    output logic       illegal_o
);

    // state | meaning
    // IDLE  | ready for a request; single-cycle ops complete here
    // BUSY  | MULT/DIV iterating, counter counts down to 0
    // DONE  | one-cycle completion, done_o high, not ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_MUL = 4'b1000;
    localparam logic [3:0] C_DIV = 4'b1001;
    localparam logic [3:0] C_NOR = 4'b1100;
`ifdef ALU_CTRL_SHIFT_EN
    localparam logic [3:0] C_SLL = 4'b0011;
    localparam logic [3:0] C_SRL = 4'b0100;
`endif

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       alu_ctrl_q;
    logic             ctrl_valid_q;
    logic             done_q;
    logic             illegal_q;

    logic [3:0]       ctrl_d;
    logic             illegal_d;
    logic             is_mul_d;
    logic             is_div_d;

    always_comb begin
        ctrl_d    = C_ADD;
        illegal_d = 1'b0;
        is_mul_d  = 1'b0;
        is_div_d  = 1'b0;
        case (ALUOp_i)
            2'b00: ctrl_d = C_ADD;
            2'b01: ctrl_d = C_SUB;
            2'b11: ctrl_d = C_OR;
            default: begin
                case (funct_i)
                    6'b100000: ctrl_d = C_ADD;
                    6'b100010: ctrl_d = C_SUB;
                    6'b100100: ctrl_d = C_AND;
                    6'b100101: ctrl_d = C_OR;
                    6'b100111: ctrl_d = C_NOR;
                    6'b101010: ctrl_d = C_SLT;
                    6'b011000: begin ctrl_d = C_MUL; is_mul_d = 1'b1; end
                    6'b011010: begin ctrl_d = C_DIV; is_div_d = 1'b1; end
`ifdef ALU_CTRL_SHIFT_EN
                    6'b000000: ctrl_d = C_SLL;
                    6'b000010: ctrl_d = C_SRL;
`endif
                    default: begin
                        ctrl_d    = C_ADD;
                        illegal_d = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_ctrl_q   <= C_ADD;
            ctrl_valid_q <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    // flush outranks a simultaneous request
                    if (valid_i && !flush_i) begin
                        alu_ctrl_q   <= ctrl_d;
                        illegal_q    <= illegal_d;
                        ctrl_valid_q <= 1'b1;
                        if (is_mul_d) begin
                            state_q <= BUSY;
                            cnt_q   <= MUL_LOAD;
                        end else if (is_div_d) begin
                            state_q <= BUSY;
                            cnt_q   <= DIV_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign stall_o      = (state_q == BUSY);
    assign ALUCtrl_o    = alu_ctrl_q;
    assign ctrl_valid_o = ctrl_valid_q;
    assign done_o       = done_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode vector table plus MULT/DIV, flush and reset sequences.
module tb_alu_control_mc;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       ready_o;
    logic [5:0] funct_i;
    logic [1:0] ALUOp_i;
    logic       flush_i;
    logic [3:0] ALUCtrl_o;
    logic       ctrl_valid_o;
    logic       stall_o;
    logic       done_o;
    logic       illegal_o;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    alu_control_mc #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .funct_i(funct_i), .ALUOp_i(ALUOp_i), .flush_i(flush_i),
        .ALUCtrl_o(ALUCtrl_o), .ctrl_valid_o(ctrl_valid_o), .stall_o(stall_o),
        .done_o(done_o), .illegal_o(illegal_o)
    );

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic [3:0] exp_ctrl;
        logic       exp_ill;
    } vec_t;

    vec_t vtab[14];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] ctrl);
        chk({tag, " ctrl"},  32'(ALUCtrl_o), 32'(ctrl));
        chk({tag, " ready"}, 32'(ready_o), 32'd1);
        chk({tag, " stall"}, 32'(stall_o), 32'd0);
        chk({tag, " cv"},    32'(ctrl_valid_o), 32'd0);
        chk({tag, " done"},  32'(done_o), 32'd0);
        chk({tag, " ill"},   32'(illegal_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;

        vtab[0]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
        vtab[1]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
        vtab[2]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
        vtab[3]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
        vtab[4]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
        vtab[5]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
        vtab[6]  = '{2'b00, 6'b100010, 4'b0010, 1'b0};
        vtab[7]  = '{2'b01, 6'b100100, 4'b0110, 1'b0};
        vtab[8]  = '{2'b11, 6'b100000, 4'b0001, 1'b0};
        vtab[9]  = '{2'b10, 6'b111111, 4'b0010, 1'b1};
        vtab[10] = '{2'b10, 6'b100100, 4'b0000, 1'b0};
`ifdef ALU_CTRL_SHIFT_EN
        vtab[11] = '{2'b10, 6'b000000, 4'b0011, 1'b0};
        vtab[12] = '{2'b10, 6'b000010, 4'b0100, 1'b0};
`else
        vtab[11] = '{2'b10, 6'b000000, 4'b0010, 1'b1};
        vtab[12] = '{2'b10, 6'b000010, 4'b0010, 1'b1};
`endif
        vtab[13] = '{2'b10, 6'b000001, 4'b0010, 1'b1};

        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        funct_i = 6'b0; ALUOp_i = 2'b00;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        chk_idle("reset", 4'b0010);

        // back-to-back single-cycle accepts
        for (int i = 0; i < 14; i++) begin
            valid_i = 1'b1; ALUOp_i = vtab[i].aluop; funct_i = vtab[i].funct;
            tick();
            chk($sformatf("vec%0d ctrl", i), 32'(ALUCtrl_o), 32'(vtab[i].exp_ctrl));
            chk($sformatf("vec%0d ill", i),  32'(illegal_o), 32'(vtab[i].exp_ill));
            chk($sformatf("vec%0d cv", i),   32'(ctrl_valid_o), 32'd1);
            chk($sformatf("vec%0d ready", i), 32'(ready_o), 32'd1);
        end
        valid_i = 1'b0;
        tick();
        chk_idle("hold", 4'b0010);

        // MUL: 4 BUSY cycles, 1 DONE, valid during BUSY ignored
        valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 6'b011000;
        tick();
        chk("mul ctrl", 32'(ALUCtrl_o), 32'h8);
        chk("mul cv", 32'(ctrl_valid_o), 32'd1);
        chk("mul stall1", 32'(stall_o), 32'd1);
        chk("mul ready1", 32'(ready_o), 32'd0);
        funct_i = 6'b100100;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("mul stall%0d", i), 32'(stall_o), 32'd1);
            chk($sformatf("mul ready%0d", i), 32'(ready_o), 32'd0);
            chk($sformatf("mul cv%0d", i), 32'(ctrl_valid_o), 32'd0);
            chk($sformatf("mul done%0d", i), 32'(done_o), 32'd0);
        end
        tick();
        chk("mul done", 32'(done_o), 32'd1);
        chk("mul done stall", 32'(stall_o), 32'd0);
        chk("mul done ready", 32'(ready_o), 32'd0);
        chk("mul done ctrl", 32'(ALUCtrl_o), 32'h8);
        valid_i = 1'b0;
        tick();
        chk_idle("mul end", 4'b1000);

        // DIV flushed on its 3rd BUSY cycle
        valid_i = 1'b1; funct_i = 6'b011010;
        tick();
        chk("div ctrl", 32'(ALUCtrl_o), 32'h9);
        valid_i = 1'b0;
        tick(); tick();
        chk("div stall3", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk_idle("div flush", 4'b1001);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o) saw_done = 1'b1;
        end
        chk("div flush no done", 32'(saw_done), 32'd0);

        // flush and valid together in IDLE: nothing accepted
        flush_i = 1'b1; valid_i = 1'b1; funct_i = 6'b100010;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        chk_idle("idle flush", 4'b1001);

        // flush during DONE has no effect
        valid_i = 1'b1; funct_i = 6'b011000;
        tick();
        valid_i = 1'b0;
        tick(); tick(); tick(); tick();
        flush_i = 1'b1;
        chk("done flush done", 32'(done_o), 32'd1);
        tick();
        flush_i = 1'b0;
        chk_idle("done flush end", 4'b1000);

        // reset mid-BUSY of DIV
        valid_i = 1'b1; funct_i = 6'b011010;
        tick();
        valid_i = 1'b0;
        tick(); tick(); tick();
        chk("rst busy stall", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_idle("rst busy", 4'b0010);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o || stall_o) saw_done = 1'b1;
        end
        chk("rst no done", 32'(saw_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
- Registered, multi-cycle-aware ALU control unit for the next CPU revision.
- Decodes ALUOp/funct into a 4-bit ALU control code, one cycle after a valid/ready handshake.
- For MULT/DIV it runs an internal iteration counter and asserts a pipeline stall until the operation completes.
- Sits between the main Control unit/ID-EX register and the ALU/MulDiv datapath.

Parameters:
- MUL_CYCLES, 4, number of BUSY cycles for MULT; legal range 1..63.
- DIV_CYCLES, 32, number of BUSY cycles for DIV; legal range 1..63.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- valid_i  input  1  request valid.
- ready_o  output  1  block can accept a request.
- funct_i  input  6  R-type funct field.
- ALUOp_i  input  2  ALU operation class from Control.
- flush_i  input  1  abort any in-flight operation.
- ALUCtrl_o  output  4  registered ALU control code.
- ctrl_valid_o  output  1  one-cycle pulse: ALUCtrl_o newly updated.
- stall_o  output  1  multi-cycle operation in progress.
- done_o  output  1  one-cycle pulse: multi-cycle operation finished.
- illegal_o  output  1  one-cycle pulse with ctrl_valid_o when the funct is undecodable.

Behaviour:
- Reset values (rst_i=1 at a clk_i edge): state=IDLE, ALUCtrl_o=4'b0010, ctrl_valid_o=0, done_o=0, illegal_o=0, counter=0. stall_o=0 and ready_o=1 follow from IDLE.
- rst_i has priority over every other input, including mid-BUSY. No done_o is produced for an operation aborted by reset.
- Codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, MUL 1000, DIV 1001, NOR 1100.
- ALUOp decode:
  - 00 -> ADD.
  - 01 -> SUB.
  - 11 -> OR (ori).
  - 10 -> by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 011000 MUL, 011010 DIV, 000000 SLL, 000010 SRL.
  - Any other funct under ALUOp=10 -> ALUCtrl_o=ADD, illegal_o=1; treated as single-cycle.
- ready_o = (state==IDLE). stall_o = (state==BUSY). Both are decoded from registered state only.
- Handshake: a request is accepted on an edge where valid_i && ready_o. Inputs are ignored when ready_o=0.
- Accept at edge N (registers update at N):
  - ALUCtrl_o and illegal_o take the decoded values.
  - ctrl_valid_o=1 for exactly the following cycle.
  - ALUCtrl_o then holds until the next accept.
- Single-cycle op: state stays IDLE; back-to-back accepts every cycle are allowed.
- FSM, MUL/DIV accept:
  - IDLE -> BUSY; counter = MUL_CYCLES-1 or DIV_CYCLES-1.
  - BUSY: counter decrements each edge. When counter==0, go to DONE.
  - stall_o is high for exactly MUL_CYCLES or DIV_CYCLES cycles.
  - DONE lasts one cycle: done_o=1, stall_o=0, ready_o=0. Then DONE -> IDLE.
  - Multi-cycle latency: accept at edge N gives done_o high in the cycle after edge N+CYCLES; ready_o returns after edge N+CYCLES+1.
- flush_i:
  - In BUSY: go to IDLE at the next edge; counter cleared; no done_o; ALUCtrl_o held.
  - In DONE: done_o still completes this cycle; flush has no effect.
  - In IDLE: the request is not accepted; ctrl_valid_o=0.
- Simultaneous flush_i and valid_i in IDLE: flush wins, nothing accepted.
- The counter never wraps: the BUSY->DONE transition occurs at 0; no decrement below 0.

Optional Feature:
- Macro: ALU_CTRL_SHIFT_EN.
- Defined: funct 000000/000010 decode to SLL 0011 / SRL 0100 (single-cycle).
- Undefined: those functs are illegal (ALUCtrl_o=ADD, illegal_o=1); codes 0011/0100 are never produced.

Test Plan:
- Reset, then release rst_i -> ALUCtrl_o=0010, ready_o=1, stall_o=0, all pulses 0.
- ALUOp=10, funct=100010 accepted -> next cycle ALUCtrl_o=0110, ctrl_valid_o=1 for one cycle. Back-to-back funct=100100 on the next edge -> 0000.
- ALUOp=10, funct=011000, MUL_CYCLES=4 -> ALUCtrl_o=1000; stall_o high 4 cycles; done_o pulse 1 cycle; ready_o low 5 cycles total. valid_i during BUSY is ignored.
- DIV (011010) with flush_i pulsed on the 3rd BUSY cycle -> IDLE next edge; stall_o=0; no done_o; ready_o=1.
- ALUOp=10, funct=111111 -> ALUCtrl_o=0010, illegal_o=1 with ctrl_valid_o. funct=000000 -> 0011 with ALU_CTRL_SHIFT_EN, illegal without.
- rst_i asserted mid-BUSY of DIV -> next cycle all reset values; no done_o ever.
